// File: rtl/mbi5153_cmd_pkg.sv
// Shared command codes, LATCH lengths and FSM state type for the MBI5153 command serializer.
package mbi5153_cmd_pkg;

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_VSYNC = 4'd1;
  localparam logic [3:0] CMD_WRC1  = 4'd2;
  localparam logic [3:0] CMD_WRC2  = 4'd3;
  localparam logic [3:0] CMD_WRC3  = 4'd4;
  localparam logic [3:0] CMD_SRST  = 4'd5;
  localparam logic [3:0] CMD_PREA  = 4'd6;

  localparam logic [3:0] LEN_VSYNC = 4'd2;
  localparam logic [3:0] LEN_WRC1  = 4'd4;
  localparam logic [3:0] LEN_WRC2  = 4'd8;
  localparam logic [3:0] LEN_WRC3  = 4'd6;
  localparam logic [3:0] LEN_SRST  = 4'd10;
  localparam logic [3:0] LEN_PREA  = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SHIFT_LO, ST_SHIFT_HI, ST_TAIL, ST_DONE
  } state_e;

  // Zero doubles as "not a bus command" (NOP and undefined codes).
  function automatic logic [3:0] latch_len(input logic [3:0] cmd);
    case (cmd)
      CMD_VSYNC: latch_len = LEN_VSYNC;
      CMD_WRC1:  latch_len = LEN_WRC1;
      CMD_WRC2:  latch_len = LEN_WRC2;
      CMD_WRC3:  latch_len = LEN_WRC3;
      CMD_SRST:  latch_len = LEN_SRST;
      CMD_PREA:  latch_len = LEN_PREA;
      default:   latch_len = 4'd0;
    endcase
  endfunction

  function automatic logic is_wrc(input logic [3:0] cmd);
    is_wrc = (cmd == CMD_WRC1) || (cmd == CMD_WRC2) || (cmd == CMD_WRC3);
  endfunction

endpackage

// File: rtl/mbi5153_cmd_serializer_if.sv
// Request/bus bundle between the panel-driver top (master) and the command serializer (slave).
interface mbi5153_cmd_serializer_if #(parameter int W = 16);
  logic         REQUEST;
  logic [3:0]   CMD;
  logic [W-1:0] DATA_R, DATA_G, DATA_B;
  logic         READY, ACTIVE, DCLK, DCLK_ENA, LATCH, R, G, B, CMD_DONE;

  modport master (
    output REQUEST, CMD, DATA_R, DATA_G, DATA_B,
    input  READY, ACTIVE, DCLK, DCLK_ENA, LATCH, R, G, B, CMD_DONE
  );
  modport slave (
    input  REQUEST, CMD, DATA_R, DATA_G, DATA_B,
    output READY, ACTIVE, DCLK, DCLK_ENA, LATCH, R, G, B, CMD_DONE
  );
endinterface

// File: rtl/mbi5153_cmd_shifter.sv
// Per-lane word shift registers; the captured word is reloaded every W bits so each chained IC sees it.
module mbi5153_cmd_shifter #(
  parameter int LANES = 3,
  parameter int W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cap_i,
  input  logic [LANES-1:0][W-1:0]   data_i,
  input  logic                      load_i,
  input  logic                      shift_i,
  output logic [LANES-1:0]          msb_o
);
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] LAST = BW'(W - 1);

  logic [BW-1:0] bit_q;
  logic          wrap;

  assign wrap = (bit_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  bit_q <= '0;
    else if (load_i)             bit_q <= '0;
    else if (shift_i)            bit_q <= wrap ? '0 : bit_q + BW'(1);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [W-1:0] hold_q, sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
        sh_q   <= '0;
      end else begin
        if (cap_i) hold_q <= data_i[l];
        if (load_i || (shift_i && wrap)) sh_q <= hold_q;
        else if (shift_i)                sh_q <= {sh_q[W-2:0], 1'b0};
      end
    end

    assign msb_o[l] = sh_q[W-1];
  end

endmodule

// File: rtl/mbi5153_cmd_serializer.sv
// MBI5153 command serializer (VSYNC/PREA/SRST/WRC1-3) onto DCLK/LATCH/RGB.
// Optional MBI5153_CMD_DBG_COUNT_EN adds DBG_CMD_CNT, a count of completed bus commands.
module mbi5153_cmd_serializer
  import mbi5153_cmd_pkg::*;
#(
  parameter int NUM_IC_CHAIN   = 4,
  parameter int IC_WORD_LENGTH = 16
) (
  input  logic        CLK,
  input  logic        RESET,
`ifdef MBI5153_CMD_DBG_COUNT_EN
  output logic [15:0] DBG_CMD_CNT,
`endif
  mbi5153_cmd_serializer_if.slave bus
);
  localparam int TMAX = NUM_IC_CHAIN * IC_WORD_LENGTH;
  localparam int KW   = $clog2(TMAX + 1);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, t_q, thr_q;
  logic          accept, nop, ld, shift;
  logic [3:0]    req_len;
  logic          req_wrc;
  logic [KW-1:0] t_d;
  logic [2:0][IC_WORD_LENGTH-1:0] cap_data;
  logic [2:0]    msb, rgb_q;
  logic          ready_q, active_q, done_q, dclk_q, ena_q, latch_q;

  assign req_len  = latch_len(bus.CMD);
  assign req_wrc  = is_wrc(bus.CMD);
  assign t_d      = req_wrc ? KW'(TMAX) : KW'(req_len);
  assign cap_data = req_wrc ? {bus.DATA_B, bus.DATA_G, bus.DATA_R} : '0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    nop     = 1'b0;
    ld      = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: if (ready_q && bus.REQUEST) begin
        if (req_len != 4'd0) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end else begin
          nop = 1'b1;
        end
      end
      ST_LOAD: begin
        ld      = 1'b1;
        state_d = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        shift   = 1'b1;
        state_d = (k_q == t_q - KW'(1)) ? ST_TAIL : ST_SHIFT_LO;
      end
      ST_TAIL: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      k_q   <= '0;
      t_q   <= '0;
      thr_q <= '0;
    end else begin
      if (accept) begin
        t_q   <= t_d;
        thr_q <= t_d - KW'(req_len);
      end
      if (ld)         k_q <= '0;
      else if (shift) k_q <= k_q + KW'(1);
    end
  end

  mbi5153_cmd_shifter #(.LANES(3), .W(IC_WORD_LENGTH)) u_shift (
    .clk     (CLK),
    .rst_n   (RESET),
    .cap_i   (accept),
    .data_i  (cap_data),
    .load_i  (ld),
    .shift_i (shift),
    .msb_o   (msb)
  );

  // Outputs follow the state one cycle later; READY re-opens one cycle after the CMD_DONE strobe.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      dclk_q   <= 1'b0;
      ena_q    <= 1'b0;
      latch_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      ready_q  <= (state_q == ST_IDLE) && (state_d == ST_IDLE);
      active_q <= state_q inside {ST_LOAD, ST_SHIFT_LO, ST_SHIFT_HI, ST_TAIL};
      done_q   <= nop || (state_q == ST_DONE);
      dclk_q   <= (state_q == ST_SHIFT_HI);
      ena_q    <= state_q inside {ST_SHIFT_LO, ST_SHIFT_HI};
      case (state_q)
        ST_SHIFT_LO: begin
          rgb_q   <= msb;
          latch_q <= (k_q >= thr_q);
        end
        ST_SHIFT_HI: ;
        default: begin
          rgb_q   <= '0;
          latch_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.READY    = ready_q;
  assign bus.ACTIVE   = active_q;
  assign bus.CMD_DONE = done_q;
  assign bus.DCLK     = dclk_q;
  assign bus.DCLK_ENA = ena_q;
  assign bus.LATCH    = latch_q;
  assign bus.R        = rgb_q[0];
  assign bus.G        = rgb_q[1];
  assign bus.B        = rgb_q[2];

`ifdef MBI5153_CMD_DBG_COUNT_EN
  logic [15:0] dbg_cnt_q;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                   dbg_cnt_q <= '0;
    else if (state_q == ST_DONE)  dbg_cnt_q <= dbg_cnt_q + 16'd1;
  end
  assign DBG_CMD_CNT = dbg_cnt_q;
`endif

endmodule

// File: tb/tb_mbi5153_cmd_serializer.sv
// Scoreboard bench for mbi5153_cmd_serializer: expected per-command bus traces are queued at issue time.
module tb_mbi5153_cmd_serializer;
  localparam int NC = 4;
  localparam int W  = 16;

  typedef struct {
    int           nedge;
    logic [255:0] vr, vg, vb, vl;
    longint       done_cyc;
    logic         ready;
  } exp_t;

  logic   CLK = 1'b0;
  logic   RESET = 1'b0;
  longint cyc = 0;
  int     checks = 0, errors = 0, valid_done = 0;
  exp_t   sb[$];

  mbi5153_cmd_serializer_if #(.W(W)) bus ();
`ifdef MBI5153_CMD_DBG_COUNT_EN
  logic [15:0] dbg_cnt;
`endif

  mbi5153_cmd_serializer #(.NUM_IC_CHAIN(NC), .IC_WORD_LENGTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
`ifdef MBI5153_CMD_DBG_COUNT_EN
    .DBG_CMD_CNT (dbg_cnt),
`endif
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.READY, bus.ACTIVE, bus.DCLK, bus.DCLK_ENA, bus.LATCH,
            bus.R, bus.G, bus.B, bus.CMD_DONE};
  endfunction

  // LATCH length per command code; 0 means no bus activity.
  function automatic int ref_len(input logic [3:0] c);
    case (c)
      4'd1: return 2;
      4'd2: return 4;
      4'd3: return 8;
      4'd4: return 6;
      4'd5: return 10;
      4'd6: return 14;
      default: return 0;
    endcase
  endfunction

  task automatic send(input logic [3:0] c, input logic [15:0] dr, dg, db);
    exp_t e;
    int   n, t;
    bit   wrc;
    n   = ref_len(c);
    wrc = (c >= 4'd2) && (c <= 4'd4);
    t   = wrc ? NC * W : n;
    e.nedge = t;
    e.vr = '0; e.vg = '0; e.vb = '0; e.vl = '0;
    for (int i = 0; i < t; i++) begin
      if (wrc) begin
        e.vr[i] = dr[W-1-(i%W)];
        e.vg[i] = dg[W-1-(i%W)];
        e.vb[i] = db[W-1-(i%W)];
      end
      e.vl[i] = (i >= t - n);
    end
    e.ready = (n == 0);
    @(negedge CLK);
    for (int i = 0; i < 400 && bus.READY !== 1'b1; i++) @(negedge CLK);
    bus.REQUEST = 1'b1;
    bus.CMD     = c;
    bus.DATA_R  = dr;
    bus.DATA_G  = dg;
    bus.DATA_B  = db;
    @(posedge CLK);
    #1;
    e.done_cyc = cyc + ((n != 0) ? 2 + 2 * t + 1 : 0);
    sb.push_back(e);
    bus.REQUEST = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: collects bits at each DCLK rising edge, compares the whole trace at CMD_DONE.
  initial begin : monitor
    exp_t         e;
    int           nedge;
    logic [255:0] ovr, ovg, ovb, ovl;
    logic         prev;
    nedge = 0; ovr = '0; ovg = '0; ovb = '0; ovl = '0; prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET !== 1'b1) begin
        nedge = 0; ovr = '0; ovg = '0; ovb = '0; ovl = '0; prev = 1'b0;
        continue;
      end
      if (bus.DCLK === 1'b1 && prev === 1'b0) begin
        chk("edge_active_ena", {bus.ACTIVE, bus.DCLK_ENA}, 2'b11);
        if (nedge < 256) begin
          ovr[nedge] = bus.R;
          ovg[nedge] = bus.G;
          ovb[nedge] = bus.B;
          ovl[nedge] = bus.LATCH;
        end
        nedge++;
      end
      prev = bus.DCLK;
      if (bus.CMD_DONE === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("dclk_edges", nedge, e.nedge);
          chk("r_seq", ovr, e.vr);
          chk("g_seq", ovg, e.vg);
          chk("b_seq", ovb, e.vb);
          chk("latch_seq", ovl, e.vl);
          chk("done_cycle", cyc, e.done_cyc);
          chk("ready_at_done", bus.READY, e.ready);
          chk("active_at_done", bus.ACTIVE, 1'b0);
          if (e.nedge != 0) valid_done++;
        end
        nedge = 0; ovr = '0; ovg = '0; ovb = '0; ovl = '0;
      end
    end
  end

  initial begin : stim
    logic [3:0] c;
    int         r;
    bus.REQUEST = 1'b0;
    bus.CMD     = '0;
    bus.DATA_R  = '0;
    bus.DATA_G  = '0;
    bus.DATA_B  = '0;

    repeat (3) @(negedge CLK);
    chk("reset_outputs", outs(), 9'b1_0000_0000);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_after_reset", outs(), 9'b1_0000_0000);

    send(4'd2, 16'hA5C3, 16'h0F0F, 16'h8001);
    wait_done(300);
    send(4'd6, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_done(100);
    send(4'd1, 16'hFFFF, 16'h1234, 16'h5678);
    wait_done(100);

    // Disturbance mid-WRC2: captured command and data must stay intact.
    send(4'd3, 16'h1357, 16'h2468, 16'hC0DE);
    repeat (15) @(negedge CLK);
    bus.REQUEST = 1'b1;
    bus.CMD     = 4'd6;
    bus.DATA_R  = 16'hFFFF;
    bus.DATA_G  = 16'h0000;
    bus.DATA_B  = 16'h5555;
    repeat (3) @(negedge CLK);
    bus.REQUEST = 1'b0;
    bus.CMD     = 4'd0;
    wait_done(300);

    send(4'hF, 16'h1111, 16'h2222, 16'h3333);
    @(negedge CLK);
    chk("undef_no_dclk", {bus.DCLK, bus.ACTIVE, bus.READY}, 3'b001);
    wait_done(20);

    // Reset around bit 20 of a WRC3: outputs clear at once, no CMD_DONE.
    send(4'd4, 16'hBEEF, 16'hCAFE, 16'hF00D);
    repeat (2 + 2 * 20) @(posedge CLK);
    #2 RESET = 1'b0;
    #1 chk("reset_abort_outputs", outs(), 9'b1_0000_0000);
    sb.delete();
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (4) @(negedge CLK);
    chk("idle_after_abort", outs(), 9'b1_0000_0000);
    send(4'd4, 16'hBEEF, 16'hCAFE, 16'hF00D);
    wait_done(300);

    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 8);
      c = (r == 8) ? 4'hF : 4'(r);
      send(c, 16'($urandom), 16'($urandom), 16'($urandom));
      wait_done(300);
    end

    repeat (5) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 0);
`ifdef MBI5153_CMD_DBG_COUNT_EN
    chk("dbg_cmd_cnt", dbg_cnt, 16'(valid_done));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbi5153_cmd_serializer.md
Name: mbi5153_cmd_serializer

Overview:
- Serializes MBI5153 driver-chain commands (VSYNC, pre-active, software reset, write config registers 1-3) onto the HUB75-style DCLK/LATCH/R/G/B bus.
- Sits beside the line/frame data path in the panel driver top. The top-level mux selects this block's outputs while ACTIVE=1.
- Config-register writes shift one 16-bit word per IC, replicated across the whole chain, with LATCH asserted for the command-specific number of trailing DCLK edges.

Parameters:
- NUM_IC_CHAIN, 4: number of MBI5153 ICs daisy-chained per lane (1..16).
- IC_WORD_LENGTH, 16: bits per IC word.

Ports:
- CLK  in  1  main clock; DCLK is derived from it.
- RESET  in  1  asynchronous, active-low reset.
- REQUEST  in  1  command request; sampled only while READY=1.
- CMD  in  4  command code, captured with REQUEST.
- DATA_R/DATA_G/DATA_B  in  16 each  config word per colour, captured with REQUEST.
- READY  out  1  block idle; accepts a request.
- ACTIVE  out  1  command in progress (bus owned).
- DCLK  out  1  serial clock.
- DCLK_ENA  out  1  high during every bit period of a shift.
- LATCH  out  1  MBI5153 LE signal.
- R/G/B  out  1 each  serial data.
- CMD_DONE  out  1  one-cycle completion strobe.

Behaviour:
- Reset values: READY=1; ACTIVE, DCLK, DCLK_ENA, LATCH, R, G, B, CMD_DONE all 0. All outputs are registered.
- Command codes and LATCH length N:
  - 0 NOP: no bus activity.
  - 1 VSYNC: N=2.
  - 2 WRC1: N=4.
  - 3 WRC2: N=8.
  - 4 WRC3: N=6.
  - 5 SRST: N=10.
  - 6 PREA: N=14.
  - Other codes: undefined.
- Bit count T:
  - WRC1-3: T = NUM_IC_CHAIN*IC_WORD_LENGTH.
  - All other valid commands: T = N, with R=G=B=0 throughout.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, TAIL, DONE.
- IDLE (READY=1):
  - REQUEST=1 with a valid code: capture CMD/DATA, set READY=0, go to LOAD.
  - REQUEST=1 with NOP or an undefined code: CMD_DONE pulses in the next cycle, no bus activity, READY stays 1.
- LOAD: set ACTIVE=1, bit index k=0, load the shift registers. Go to SHIFT_LO.
- SHIFT_LO:
  - DCLK=0, DCLK_ENA=1.
  - R/G/B = MSB of the current word (word reloaded from captured DATA every IC_WORD_LENGTH bits, so every IC gets the same word).
  - LATCH = (k >= T-N).
- SHIFT_HI:
  - DCLK=1; data and LATCH held.
  - Increment k. If k was T-1, go to TAIL; otherwise go to SHIFT_LO.
- Bit period is 2 CLK cycles. Data and LATCH change only while DCLK=0.
- TAIL: one cycle with DCLK=0, LATCH=0, R/G/B=0, DCLK_ENA=0.
- DONE:
  - CMD_DONE=1 for exactly one cycle; ACTIVE=0 in this cycle.
  - READY=1 from the following cycle.
  - The requester must drop REQUEST by the CMD_DONE cycle; a REQUEST still high when READY returns starts a new command.
- Total latency from request acceptance to CMD_DONE: 2 + 2T + 1 CLK cycles (LOAD + 2T shift cycles + TAIL, then CMD_DONE).
- REQUEST while READY=0 is ignored. CMD/DATA changes after capture have no effect.
- Reset asserted mid-command: all outputs return immediately to reset values; no CMD_DONE is issued.
- Bit counter width: clog2(NUM_IC_CHAIN*IC_WORD_LENGTH+1).
- N is always <= T for the WRC commands, which requires NUM_IC_CHAIN*IC_WORD_LENGTH >= 8.

Optional Feature:
- Macro: MBI5153_CMD_DBG_COUNT_EN.
- When defined: extra output DBG_CMD_CNT[15:0]. It counts CMD_DONE strobes of valid (non-NOP) commands, wraps at 16'hFFFF to 0, and resets to 0.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package mbi5153_cmd_pkg holds:
  - the CMD code constants (CMD_NOP, CMD_VSYNC, CMD_WRC1, CMD_WRC2, CMD_WRC3, CMD_SRST, CMD_PREA);
  - the LATCH-length constants;
  - the function latch_len(cmd), which returns 0 for invalid codes;
  - the state enum typedef.
- One natural sub-module: mbi5153_cmd_shifter, the 3-lane word shift registers with per-word reload.

Test Plan:
- Reset: hold RESET=0 -> READY=1, all other outputs 0; after release, idle outputs remain stable.
- WRC1 with DATA_R=16'hA5C3, NUM_IC_CHAIN=4 -> 64 DCLK rising edges; R sequence equals 16'hA5C3 MSB-first repeated 4 times; LATCH high on edges 61-64 only; CMD_DONE at cycle 131 after acceptance.
- PREA -> 14 DCLK edges with LATCH high on all of them and R=G=B=0; VSYNC -> 2 edges, LATCH high on both.
- REQUEST pulsed mid-WRC2 and CMD changed mid-shift -> no disturbance; exactly 8 LATCH-high edges at the end; a single CMD_DONE.
- CMD=4'hF requested -> no DCLK activity; CMD_DONE pulses the next cycle; READY stays 1.
- RESET asserted at bit 20 of a WRC3 -> outputs cleared immediately; no CMD_DONE; a new request afterwards completes normally.
